// File: rtl/arith_op_driver.sv
// Initiator-side sequencer for a fixed-latency registered arithmetic unit:
// accepts commands, drives and holds operands, waits LAT edges, returns the result.
module arith_op_driver #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_a,
  input  logic [31:0]       cmd_b,
  input  logic [1:0]        cmd_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [1:0]        alu_sel,
  input  logic [31:0]       alu_r,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [1:0]        res_op,
  output logic              res_err,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT_V = 4'(LAT);

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               err_q;
  logic [31:0]        alu_a_q;
  logic [31:0]        alu_b_q;
  logic [1:0]         alu_sel_q;
  logic [31:0]        res_data_q;
  logic [1:0]         res_op_q;
  logic               res_err_q;
  logic [CNT_W-1:0]   op_count_q;

  logic               cmd_ready_s;
  logic               accept_s;
  logic               res_hs_s;
  logic               div_zero_s;

  // Handshake decode; cmd_ready depends on res_ready but never on cmd_valid.
  always_comb begin
    cmd_ready_s = 1'b0;
    res_hs_s    = 1'b0;
    if (state_q == ST_IDLE) begin
      cmd_ready_s = 1'b1;
    end else if (state_q == ST_DONE) begin
      cmd_ready_s = res_ready;
      res_hs_s    = res_ready;
    end else begin
      cmd_ready_s = 1'b0;
      res_hs_s    = 1'b0;
    end
    accept_s   = cmd_valid & cmd_ready_s;
    div_zero_s = (cmd_op == 2'b11) && (cmd_b == 32'd0);
  end

  // Sequencer FSM with all outputs held in registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      err_q      <= 1'b0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_sel_q  <= 2'b00;
      res_data_q <= 32'd0;
      res_op_q   <= 2'b00;
      res_err_q  <= 1'b0;
      op_count_q <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            res_data_q <= alu_r;
            res_op_q   <= alu_sel_q;
            res_err_q  <= err_q;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (res_hs_s) begin
            op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q    <= accept_s ? ST_WAIT : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Operands only move on acceptance, so the unit sees stable inputs.
      if (accept_s) begin
        alu_a_q   <= cmd_a;
        alu_b_q   <= cmd_b;
        alu_sel_q <= cmd_op;
        err_q     <= div_zero_s;
        cnt_q     <= LAT_V;
      end
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/arith_op_driver.md
# arith_op_driver

Initiator-side sequencer for the two-stage registered integer arithmetic unit (add/sub/mul/div selected by a 2-bit op code, result two clock edges after operands). It accepts operation commands over a valid/ready handshake and drives the unit's operand and select inputs, holding them stable. It waits the unit's fixed latency, captures the 32-bit result, and returns it over a valid/ready result handshake. It also provides a divide-by-zero flag and a completed-operation counter.

## Interface
- LAT, default 2: clock edges from driving operands until `alu_r` holds the matching result; legal range 1..15.
- CNT_W, default 16: width of the completed-operation counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset: 0 resets immediately; release is synchronous to clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_a  in  32  signed operand A (int).
- cmd_b  in  32  signed operand B (int).
- cmd_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- alu_a  out  32  operand A to arithmetic unit.
- alu_b  out  32  operand B to arithmetic unit.
- alu_sel  out  2  op select to arithmetic unit.
- alu_r  in  32  result from arithmetic unit.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_data  out  32  captured result.
- res_op  out  2  op code of the captured result.
- res_err  out  1  1 when op was div and B == 0 (res_data is then -1 as returned by the unit).
- op_count  out  CNT_W  results delivered since reset; wraps.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_sel;
  - latch err = (cmd_op==11 && cmd_b==0);
  - load wait counter with LAT;
  - go to WAIT.
- WAIT: counter decrements each edge. On the edge where counter==0:
  - capture alu_r into res_data and alu_sel into res_op;
  - set res_err from the latched err;
  - go to DONE.
- DONE: res_valid=1; res_data, res_op and res_err are held stable until res_valid&&res_ready. On that handshake:
  - op_count increments, wrapping from 2^CNT_W-1 to 0;
  - if cmd_valid is also high, the next command is accepted on the same edge and the FSM goes to WAIT;
  - otherwise the FSM goes to IDLE.
- cmd_ready = (state==IDLE) || (state==DONE && res_ready). This is combinational from res_ready; there is no combinational path from cmd_valid.
- alu_a/alu_b/alu_sel change only on command acceptance and otherwise hold their last values, including in IDLE.
- The driver performs no arithmetic and passes alu_r through unmodified. res_err is computed only from the latched operands.
- Reset (rst=0, asynchronous, any state, including mid-WAIT or DONE):
  - state=IDLE, cmd_ready=1;
  - alu_a=0, alu_b=0, alu_sel=00;
  - res_valid=0, res_data=0, res_op=00, res_err=0, op_count=0;
  - any in-flight operation is discarded and no result is produced for it.

## Timing
- Command accepted at edge E0: alu_* valid after E0; the unit registers them at E1 and updates alu_r at E2 (for LAT=2).
- Capture occurs at edge E0+LAT+1; res_valid is high after that edge.
- Latency from acceptance to res_valid = LAT+1 cycles (3 at default).
- Maximum throughput: one operation per LAT+2 cycles with res_ready and cmd_valid held high (4 cycles at default).
- res_valid never drops without a handshake. cmd_ready is 0 throughout WAIT.
- cmd_valid asserted during WAIT or DONE with res_ready=0 is not accepted; the command must be held by the source.

## Test plan
- Reset values: hold rst=0 for 3 cycles, release -> cmd_ready=1, res_valid=0, all outputs 0, op_count=0.
- Single add: cmd a=7, b=5, op=00 accepted at E0, res_ready=1 -> res_valid rises after E0+3, res_data=12, res_op=00, res_err=0, op_count=1 after the handshake.
- Back-to-back with stalls: ops sub(3,10), mul(-4,6), div(100,7) with cmd_valid held, and res_ready low for 5 cycles on the second result -> results -7, -24, 14 in order; res_data stable while stalled; cmd_ready=0 until the handshake; acceptance spacing 4 cycles when unstalled.
- Divide by zero: div(9,0) -> res_data=-1 (0xFFFFFFFF), res_err=1; next add(1,1) -> res_err=0, res_data=2.
- Reset mid-operation: accept mul(3,3), assert rst=0 one cycle later (WAIT), release -> no res_valid for that op, state IDLE, op_count=0.
- Counter wrap with CNT_W=2: complete 5 operations -> op_count sequence 1,2,3,0,1.
